rv32im_return_stack: RTL

//  Return-address stack (RAS) for jump prediction. Sits directly downstream of the decode stage.

---
 rtl/rv32im_return_stack_if.sv | 29 ++
 rtl/rv32im_return_stack.sv | 103 ++++++++++
 2 files changed

// File: rtl/rv32im_return_stack_if.sv
// Decode-to-RAS interface: qualified push/pop/undo requests in, predicted return target and status out.
// The master modport belongs to decode/fetch; the slave modport belongs to the return stack.
interface rv32im_return_stack_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             en_i;
    logic             push_i;
    logic             pop_i;
    logic [XLEN-1:0]  push_addr_i;
    logic             undo_i;
    logic [XLEN-1:0]  top_addr_o;
    logic             top_valid_o;
    logic [PTR_W:0]   count_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output en_i, push_i, pop_i, push_addr_i, undo_i,
        input  top_addr_o, top_valid_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  en_i, push_i, pop_i, push_addr_i, undo_i,
        output top_addr_o, top_valid_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/rv32im_return_stack.sv
// Return-address stack for return-target prediction, with a one-level undo so a
// squashed speculative call or return can be rolled back.
module rv32im_return_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rv32im_return_stack_if.slave  ras
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tp;
    logic [PTR_W:0]   count;
    logic             overflow_q;
    logic             underflow_q;

    // Undo snapshot: pointer/count before the last effective op and the entry it overwrote.
    logic             snap_valid;
    logic [PTR_W-1:0] snap_tp;
    logic [PTR_W:0]   snap_count;
    logic [PTR_W-1:0] snap_widx;
    logic [XLEN-1:0]  snap_wdata;
    logic             snap_wvalid;

    logic [PTR_W-1:0] tp_inc;
    logic [PTR_W-1:0] tp_dec;
    logic             empty;
    logic             full;

    assign tp_inc = tp + 1'b1;
    assign tp_dec = tp - 1'b1;
    assign empty  = (count == '0);
    assign full   = (count == CNT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tp          <= '0;
            count       <= '0;
            snap_valid  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (ras.undo_i) begin
                // Undo wins over any same-cycle request; nothing else happens this cycle.
                if (snap_valid) begin
                    tp         <= snap_tp;
                    count      <= snap_count;
                    snap_valid <= 1'b0;
                    if (snap_wvalid) begin
                        mem[snap_widx] <= snap_wdata;
                    end
                end
            end else if (ras.en_i) begin
                if (ras.push_i && (!ras.pop_i || empty)) begin
                    snap_valid  <= 1'b1;
                    snap_tp     <= tp;
                    snap_count  <= count;
                    snap_widx   <= tp_inc;
                    snap_wdata  <= mem[tp_inc];
                    snap_wvalid <= 1'b1;
                    mem[tp_inc] <= ras.push_addr_i;
                    tp          <= tp_inc;
                    if (full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end else if (ras.push_i) begin
                    // Coroutine swap: replace the top in place.
                    snap_valid  <= 1'b1;
                    snap_tp     <= tp;
                    snap_count  <= count;
                    snap_widx   <= tp;
                    snap_wdata  <= mem[tp];
                    snap_wvalid <= 1'b1;
                    mem[tp]     <= ras.push_addr_i;
                end else if (ras.pop_i) begin
                    if (empty) begin
                        underflow_q <= 1'b1;
                    end else begin
                        snap_valid  <= 1'b1;
                        snap_tp     <= tp;
                        snap_count  <= count;
                        snap_wvalid <= 1'b0;
                        tp          <= tp_dec;
                        count       <= count - 1'b1;
                    end
                end
            end
        end
    end

    assign ras.top_addr_o  = empty ? '0 : mem[tp];
    assign ras.top_valid_o = !empty;
    assign ras.count_o     = count;
    assign ras.overflow_o  = overflow_q;
    assign ras.underflow_o = underflow_q;
endmodule
